// File: rtl/cam_partition_gate_ctrl_if.sv
// Owner/CAM-facing bundle of the partition gating controller.
// The master side is the owner structure; the controller takes the slave side.
interface cam_partition_gate_ctrl_if #(
   parameter int NUM_PARTS     = 4,
   parameter int NUM_PARTS_LOG = 2
);
   logic                     cfgReq_i;
   logic [NUM_PARTS_LOG:0]   cfgActiveParts_i;
   logic [NUM_PARTS-1:0]     occupancy_i;
   logic                     ramReady_i;
   logic [NUM_PARTS-1:0]     partitionGated_o;
   logic [NUM_PARTS_LOG:0]   activeCnt_o;
   logic                     stallWr_o;
   logic                     busy_o;
   logic                     cfgAck_o;

   modport master (
      output cfgReq_i, cfgActiveParts_i, occupancy_i, ramReady_i,
      input  partitionGated_o, activeCnt_o, stallWr_o, busy_o, cfgAck_o
   );

   modport slave (
      input  cfgReq_i, cfgActiveParts_i, occupancy_i, ramReady_i,
      output partitionGated_o, activeCnt_o, stallWr_o, busy_o, cfgAck_o
   );
endinterface

// File: rtl/cam_partition_gate_ctrl.sv
// Partition gating controller for the partitioned CAM: drains partitions before
// gating them on a shrink, ungates and waits for CAM ready on a grow.
module cam_partition_gate_ctrl #(
   parameter int NUM_PARTS     = 4,
   parameter int NUM_PARTS_LOG = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   cam_partition_gate_ctrl_if.slave bus
);
   localparam int CW = NUM_PARTS_LOG + 1;
   localparam logic [CW-1:0]    PARTS_MAX   = CW'(NUM_PARTS);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, DRAIN, GATE, WAKE, WAIT_RDY, DONE} state_t;

   state_t                 state, stateNxt;
   logic [NUM_PARTS-1:0]   gated, gatedNxt;
   logic [CW-1:0]          actCnt, actCntNxt;
   logic [CW-1:0]          tgt, tgtNxt;
   logic [CNT_W-1:0]       cnt, cntNxt;
   logic                   stall, stallNxt;
   logic                   ack, ackNxt;

   logic [CW-1:0]          clampReq;
   logic [NUM_PARTS-1:0]   geAct, geTgt, geReq;
   logic [NUM_PARTS-1:0]   killMask, wakeMask;

   assign clampReq = (bus.cfgActiveParts_i == '0)       ? CW'(1)    :
                     (bus.cfgActiveParts_i > PARTS_MAX) ? PARTS_MAX :
                     bus.cfgActiveParts_i;

   // ge*[p] marks partitions at or above a count, i.e. the gated set for that count
   for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
      assign geAct[p] = (CW'(p) >= actCnt);
      assign geTgt[p] = (CW'(p) >= tgt);
      assign geReq[p] = (CW'(p) >= clampReq);
   end

   assign killMask = geTgt & ~geAct;
   assign wakeMask = geAct & ~geReq;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         gated  <= '0;
         actCnt <= PARTS_MAX;
         tgt    <= PARTS_MAX;
         cnt    <= '0;
         stall  <= 1'b0;
         ack    <= 1'b0;
      end else begin
         state  <= stateNxt;
         gated  <= gatedNxt;
         actCnt <= actCntNxt;
         tgt    <= tgtNxt;
         cnt    <= cntNxt;
         stall  <= stallNxt;
         ack    <= ackNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE: begin
            if (bus.cfgReq_i) begin
               if (clampReq == actCnt)     stateNxt = DONE;
               else if (clampReq < actCnt) stateNxt = DRAIN;
               else                        stateNxt = WAKE;
            end
         end
         DRAIN:    if ((bus.occupancy_i & killMask) == '0) stateNxt = GATE;
         GATE:     if (cnt == '0) stateNxt = DONE;
         WAKE:     if (cnt == '0) stateNxt = WAIT_RDY;
         WAIT_RDY: if (bus.ramReady_i) stateNxt = DONE;
         DONE:     stateNxt = IDLE;
         default:  stateNxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; they follow the state transition
   always_comb begin
      gatedNxt  = gated;
      actCntNxt = actCnt;
      tgtNxt    = tgt;
      cntNxt    = cnt;
      stallNxt  = stateNxt inside {DRAIN, GATE, WAKE, WAIT_RDY};
      ackNxt    = (stateNxt == DONE);
      case (state)
         IDLE: begin
            if (bus.cfgReq_i) begin
               tgtNxt = clampReq;
               if (stateNxt == WAKE) begin
                  gatedNxt = gated & ~wakeMask;
                  cntNxt   = SETTLE_LOAD;
               end
            end
         end
         DRAIN: begin
            if (stateNxt == GATE) begin
               gatedNxt = gated | killMask;
               cntNxt   = SETTLE_LOAD;
            end
         end
         GATE: begin
            if (cnt == '0) actCntNxt = tgt;
            else           cntNxt    = cnt - 1'b1;
         end
         WAKE:     if (cnt != '0) cntNxt = cnt - 1'b1;
         WAIT_RDY: if (bus.ramReady_i) actCntNxt = tgt;
         default: ;
      endcase
   end

   assign bus.partitionGated_o = gated;
   assign bus.activeCnt_o      = actCnt;
   assign bus.stallWr_o        = stall;
   assign bus.cfgAck_o         = ack;
   assign bus.busy_o           = (state != IDLE);
endmodule

// File: tb/tb_cam_partition_gate_ctrl.sv
// Randomized bench for cam_partition_gate_ctrl: each request is checked against
// timelines derived from the active-count arithmetic (drain, settle, ready wait).
module tb_cam_partition_gate_ctrl;
   localparam int NP     = 4;
   localparam int NPL    = 2;
   localparam int SETTLE = 4;

   logic clk = 1'b0;
   logic reset;
   int   nTests = 0;
   int   nFail  = 0;
   int   mAct   = NP;

   always #5 clk = ~clk;

   cam_partition_gate_ctrl_if #(.NUM_PARTS(NP), .NUM_PARTS_LOG(NPL)) bus ();

   cam_partition_gate_ctrl #(
      .NUM_PARTS(NP), .NUM_PARTS_LOG(NPL), .SETTLE_CYCLES(SETTLE), .CNT_W(3)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      nTests++;
      if (obs != exp) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int clampT(input int r);
      if (r == 0) return 1;
      if (r > NP) return NP;
      return r;
   endfunction

   function automatic logic [NP-1:0] gateVec(input int n);
      logic [NP-1:0] v;
      for (int p = 0; p < NP; p++) v[p] = (p >= n);
      return v;
   endfunction

   function automatic logic [NP-1:0] rndOcc(input logic [NP-1:0] kill, input bit dirty);
      logic [NP-1:0] r, k;
      r = NP'($urandom) & ~kill;
      k = kill & NP'($urandom);
      if (k == '0) k = kill;
      if (dirty) r = r | k;
      return r;
   endfunction

   task automatic stray();
      bus.cfgReq_i         = ($urandom_range(0, 3) == 0);
      bus.cfgActiveParts_i = 3'($urandom_range(0, 7));
   endtask

   task automatic checkIdle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idleBusy",  bus.busy_o, 0);
         chk("idleStall", bus.stallWr_o, 0);
         chk("idleAck",   bus.cfgAck_o, 0);
         chk("idleGate",  bus.partitionGated_o, gateVec(mAct));
         chk("idleAct",   bus.activeCnt_o, mAct);
      end
   endtask

   task automatic checkBusy(input string tag, input logic [NP-1:0] g);
      chk({tag, "Busy"},  bus.busy_o, 1);
      chk({tag, "Stall"}, bus.stallWr_o, 1);
      chk({tag, "Ack"},   bus.cfgAck_o, 0);
      chk({tag, "Gate"},  bus.partitionGated_o, g);
      chk({tag, "Act"},   bus.activeCnt_o, mAct);
   endtask

   task automatic doReq(input int req, input int drainCyc, input int rdyDly);
      int t;
      logic [NP-1:0] oldG, newG, kill;
      t    = clampT(req);
      oldG = gateVec(mAct);
      newG = gateVec(t);
      kill = newG & ~oldG;
      @(negedge clk);
      chk("accIdle", bus.busy_o, 0);
      bus.cfgReq_i         = 1'b1;
      bus.cfgActiveParts_i = 3'(req);
      bus.occupancy_i      = rndOcc(kill, drainCyc > 0);
      bus.ramReady_i       = 1'($urandom);
      if (t < mAct) begin
         for (int c = 1; c <= drainCyc + 1; c++) begin
            @(negedge clk);
            checkBusy("drain", oldG);
            stray();
            if (c == drainCyc + 1) bus.occupancy_i = rndOcc(kill, 1'b0);
            else                   bus.occupancy_i = rndOcc(kill, 1'b1);
         end
         for (int c = 1; c <= SETTLE; c++) begin
            @(negedge clk);
            checkBusy("gate", newG);
            stray();
            bus.occupancy_i = NP'($urandom);
         end
      end else if (t > mAct) begin
         for (int c = 1; c <= SETTLE + 1 + rdyDly; c++) begin
            @(negedge clk);
            checkBusy("wake", newG);
            stray();
            if (c < SETTLE) bus.ramReady_i = 1'($urandom);
            else            bus.ramReady_i = (c >= SETTLE + 1 + rdyDly);
         end
      end
      @(negedge clk);
      chk("doneAck",   bus.cfgAck_o, 1);
      chk("doneBusy",  bus.busy_o, 1);
      chk("doneStall", bus.stallWr_o, 0);
      chk("doneGate",  bus.partitionGated_o, newG);
      chk("doneAct",   bus.activeCnt_o, t);
      bus.cfgReq_i = 1'b0;
      mAct = t;
      checkIdle(1);
   endtask

   initial begin
      reset = 1'b0;
      bus.cfgReq_i = 1'b0;
      bus.cfgActiveParts_i = '0;
      bus.occupancy_i = '0;
      bus.ramReady_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstGate",  bus.partitionGated_o, 0);
      chk("rstAct",   bus.activeCnt_o, NP);
      chk("rstStall", bus.stallWr_o, 0);
      chk("rstBusy",  bus.busy_o, 0);
      chk("rstAck",   bus.cfgAck_o, 0);
      reset = 1'b1;
      checkIdle(4);

      doReq(2, 10, 0);   // shrink 4->2 with long drain
      checkIdle(2);
      doReq(4, 0, 6);    // grow 2->4, ready late
      checkIdle(1);
      doReq(0, 0, 0);    // clamps to 1
      chk("clampLow", bus.partitionGated_o, 4'b1110);
      doReq(7, 0, 2);    // clamps to 4
      chk("clampHigh", bus.activeCnt_o, 4);
      doReq(3, 2, 0);
      doReq(3, 0, 0);    // equal request: straight to DONE
      checkIdle(1);

      // reset during DRAIN of 4->1 drops the request without an ack
      doReq(4, 0, 0);
      @(negedge clk);
      bus.cfgReq_i = 1'b1;
      bus.cfgActiveParts_i = 3'd1;
      bus.occupancy_i = 4'b1110;
      repeat (3) begin
         @(negedge clk);
         bus.cfgReq_i = 1'b0;
         chk("preRstStall", bus.stallWr_o, 1);
      end
      reset = 1'b0;
      @(negedge clk);
      chk("midRstGate",  bus.partitionGated_o, 0);
      chk("midRstAct",   bus.activeCnt_o, NP);
      chk("midRstStall", bus.stallWr_o, 0);
      chk("midRstBusy",  bus.busy_o, 0);
      chk("midRstAck",   bus.cfgAck_o, 0);
      reset = 1'b1;
      bus.occupancy_i = '0;
      mAct = NP;
      checkIdle(8);

      for (int i = 0; i < 60; i++) begin
         doReq($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 4));
         checkIdle($urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
